config_chain_receiver: RTL and testbench

- Fabric-side receiver for the serial configuration protocol driven by the top-level stimulus generator.
- Deserialises config_in while config_en is high and forwards the chain tail on config_out, so chains can be daisy-chained and the tail compared against the expected config out.
- Counts bits, commits a full frame to a stable parallel word and flags short or over-length loads.
- Gates the fabric enable so user logic runs only on a validly committed configuration.

---
 rtl/config_chain_receiver.sv | 119 +++++++++++
 tb/tb_config_chain_receiver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/config_chain_receiver.sv
// Fabric-side receiver for the serial configuration chain: shifts config_in while config_en is
// high, commits exact-length frames to config_word and gates fabric_en on a good commit.
module config_chain_receiver #(
   parameter int unsigned CONFIG_WIDTH = 64,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                    config_clk,
   input  logic                    sys_reset,
   input  logic                    config_en,
   input  logic                    config_in,
   output logic                    config_out,
   output logic [CONFIG_WIDTH-1:0] config_word,
   output logic                    config_valid,
   output logic                    config_done,
   output logic                    err_short,
   output logic                    err_long,
   output logic [CNT_WIDTH-1:0]    bit_count,
   output logic                    fabric_en
);

   typedef enum logic [1:0] {StIdle, StLoad, StDone, StError} state_e;

   localparam logic [CNT_WIDTH-1:0] CntMax  = '1;
   localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(CONFIG_WIDTH);

   state_e                  r_state, w_state_nxt;
   logic [CONFIG_WIDTH-1:0] r_shift, w_shift_nxt;
   logic [CONFIG_WIDTH-1:0] r_word, w_word_nxt;
   logic [CNT_WIDTH-1:0]    r_count, w_count_nxt;
   logic                    r_valid, w_valid_nxt;
   logic                    r_done, w_done_nxt;
   logic                    r_err_short, w_err_short_nxt;
   logic                    r_err_long, w_err_long_nxt;
   logic                    r_fabric_en, w_fabric_en_nxt;

   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_word_nxt      = r_word;
      w_count_nxt     = r_count;
      w_valid_nxt     = r_valid;
      w_done_nxt      = 1'b0;
      w_err_short_nxt = r_err_short;
      w_err_long_nxt  = r_err_long;

      // The chain keeps shifting in every state so over-length bits pass through to the tail.
      if (config_en) begin
         w_shift_nxt = {r_shift[CONFIG_WIDTH-2:0], config_in};
      end

      unique case (r_state)
         StLoad: begin
            if (config_en) begin
               if (r_count != CntMax) begin
                  w_count_nxt = r_count + CNT_WIDTH'(1);
               end
               if (r_count >= CntFull) begin
                  w_err_long_nxt = 1'b1;
               end
            end else if (r_count == CntFull && !r_err_long) begin
               w_word_nxt  = r_shift;
               w_valid_nxt = 1'b1;
               w_done_nxt  = 1'b1;
               w_state_nxt = StDone;
            end else begin
               if (r_count < CntFull) begin
                  w_err_short_nxt = 1'b1;
               end
               w_state_nxt = StError;
            end
         end
         default: begin
            if (config_en) begin
               w_count_nxt     = CNT_WIDTH'(1);
               w_err_short_nxt = 1'b0;
               w_err_long_nxt  = 1'b0;
               w_valid_nxt     = 1'b0;
               w_state_nxt     = StLoad;
            end
         end
      endcase

      w_fabric_en_nxt = w_valid_nxt & ~config_en;
   end

   always_ff @(posedge config_clk) begin
      if (!sys_reset) begin
         r_state     <= StIdle;
         r_shift     <= '0;
         r_word      <= '0;
         r_count     <= '0;
         r_valid     <= 1'b0;
         r_done      <= 1'b0;
         r_err_short <= 1'b0;
         r_err_long  <= 1'b0;
         r_fabric_en <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_word      <= w_word_nxt;
         r_count     <= w_count_nxt;
         r_valid     <= w_valid_nxt;
         r_done      <= w_done_nxt;
         r_err_short <= w_err_short_nxt;
         r_err_long  <= w_err_long_nxt;
         r_fabric_en <= w_fabric_en_nxt;
      end
   end

   assign config_out   = r_shift[CONFIG_WIDTH-1];
   assign config_word  = r_word;
   assign config_valid = r_valid;
   assign config_done  = r_done;
   assign err_short    = r_err_short;
   assign err_long     = r_err_long;
   assign bit_count    = r_count;
   assign fabric_en    = r_fabric_en;

endmodule

// File: tb/tb_config_chain_receiver.sv
// Randomized bench for config_chain_receiver against a frame-level reference model
// (bit history, frame length, sticky flags).
module tb_config_chain_receiver;

   localparam int W   = 8;
   localparam int CW  = 4;
   localparam int MAX = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          din;
   logic          w_out;
   logic [W-1:0]  w_word;
   logic          w_valid;
   logic          w_done;
   logic          w_err_short;
   logic          w_err_long;
   logic [CW-1:0] w_count;
   logic          w_fabric_en;

   config_chain_receiver #(
      .CONFIG_WIDTH(W),
      .CNT_WIDTH   (CW)
   ) dut (
      .config_clk  (clk),
      .sys_reset   (rst_n),
      .config_en   (en),
      .config_in   (din),
      .config_out  (w_out),
      .config_word (w_word),
      .config_valid(w_valid),
      .config_done (w_done),
      .err_short   (w_err_short),
      .err_long    (w_err_long),
      .bit_count   (w_count),
      .fabric_en   (w_fabric_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the last W bits shifted, plus the length of the current frame.
   bit           hist[$];
   int           len;
   bit           in_frame;
   logic [W-1:0] m_word;
   bit           m_valid, m_done, m_es, m_el, m_fab;

   function automatic void model_reset();
      hist.delete();
      len      = 0;
      in_frame = 0;
      m_word   = '0;
      m_valid  = 0;
      m_done   = 0;
      m_es     = 0;
      m_el     = 0;
      m_fab    = 0;
   endfunction

   function automatic logic [W-1:0] model_pack();
      logic [W-1:0] v = '0;
      for (int i = 0; i < hist.size(); i++) v[hist.size()-1-i] = hist[i];
      return v;
   endfunction

   function automatic void model_step(input logic r, input logic e, input logic d);
      if (!r) begin
         model_reset();
         return;
      end
      m_done = 0;
      if (e) begin
         hist.push_back(d);
         if (hist.size() > W) void'(hist.pop_front());
         if (!in_frame) begin
            in_frame = 1;
            len      = 1;
            m_es     = 0;
            m_el     = 0;
            m_valid  = 0;
         end else begin
            len++;
            if (len > W) m_el = 1;
         end
      end else if (in_frame) begin
         in_frame = 0;
         if (len == W && !m_el) begin
            m_word  = model_pack();
            m_valid = 1;
            m_done  = 1;
         end else if (len < W) begin
            m_es = 1;
         end
      end
      m_fab = m_valid && !e;
   endfunction

   task automatic compare_all();
      logic [W-1:0] sh;
      sh = model_pack();
      check("config_out", 32'(w_out), 32'(sh[W-1]));
      check("config_word", 32'(w_word), 32'(m_word));
      check("config_valid", 32'(w_valid), 32'(m_valid));
      check("config_done", 32'(w_done), 32'(m_done));
      check("err_short", 32'(w_err_short), 32'(m_es));
      check("err_long", 32'(w_err_long), 32'(m_el));
      check("bit_count", 32'(w_count), 32'((len > MAX) ? MAX : len));
      check("fabric_en", 32'(w_fabric_en), 32'(m_fab));
   endtask

   task automatic cycle(input logic r, input logic e, input logic d);
      rst_n = r;
      en    = e;
      din   = d;
      @(posedge clk);
      model_step(r, e, d);
      #1;
      compare_all();
      @(negedge clk);
   endtask

   // Sends bits[len-1] first; reset_at >= 0 asserts reset on that bit index.
   task automatic send_frame(input logic [31:0] bits, input int n, input int gap,
                             input int reset_at);
      for (int i = 0; i < n; i++) begin
         cycle((i == reset_at) ? 1'b0 : 1'b1, 1'b1, bits[n-1-i]);
      end
      for (int i = 0; i < gap; i++) cycle(1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      din   = 1'b0;
      model_reset();
      @(negedge clk);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);

      send_frame(32'hB2, 8, 2, -1);
      check("b2_word", 32'(w_word), 32'hB2);
      check("b2_fabric", 32'(w_fabric_en), 32'd1);
      send_frame(32'hB2, 8, 1, -1);
      send_frame(32'h15, 5, 2, -1);
      check("short_keeps_word", 32'(w_word), 32'hB2);
      check("short_flag", 32'(w_err_short), 32'd1);
      send_frame(32'h1A5, 9, 2, -1);
      check("long_flag", 32'(w_err_long), 32'd1);
      send_frame(32'h3C, 8, 2, -1);
      send_frame(32'h99, 8, 2, 3);
      send_frame(32'h5A, 8, 2, -1);
      send_frame(32'h0F, 8, 1, -1);
      send_frame(32'hF0, 8, 2, -1);
      check("b2b_word", 32'(w_word), 32'hF0);
      send_frame(32'h000ABCDE, 20, 2, -1);
      check("saturate", 32'(w_count), 32'(MAX));

      for (int k = 0; k < 80; k++) begin
         int kind = int'($urandom_range(0, 9));
         int n;
         int rat = -1;
         logic [31:0] bits = $urandom();
         if (kind < 5) n = W;
         else if (kind < 7) n = int'($urandom_range(1, W - 1));
         else if (kind < 9) n = int'($urandom_range(W + 1, 20));
         else begin
            n   = W;
            rat = int'($urandom_range(0, W - 1));
         end
         send_frame(bits, n, int'($urandom_range(1, 3)), rat);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
